// File: rtl/posit_extract_pipe.sv
// Two-stage, back-pressurable posit field extractor: S1 captures sign, special
// flags and the two's-complement-normalised body; S2 decodes regime, exponent and fraction.
module posit_extract_pipe #(
    parameter  int N  = 8,
    parameter  int ES = 3,
    parameter  int TW = 4,
    localparam int RS = $clog2(N) + 1
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    InValid,
    output logic                    InReady,
    input  logic [N-1:0]            In,
    input  logic [TW-1:0]           InTag,
    output logic                    OutValid,
    input  logic                    OutReady,
    output logic                    Sign,
    output logic                    Zero,
    output logic                    NaR,
    output logic signed [RS-1:0]    RegimeValue,
    output logic [ES-1:0]           Exponent,
    output logic [N-ES-3:0]         Mantissa,
    output logic signed [RS+ES-1:0] TotalExp,
    output logic [TW-1:0]           OutTag
);
    localparam int FW = N - ES - 3;

    // Length of the leading run of identical bits, 1..N-1.
    function automatic logic [RS-1:0] run_len(input logic [N-2:0] rem);
        logic          stop;
        logic [RS-1:0] k;
        stop = 1'b0;
        k    = '0;
        for (int i = N - 2; i >= 0; i--) begin
            if (!stop && (rem[i] == rem[N-2])) begin
                k = k + RS'(1);
            end else begin
                stop = 1'b1;
            end
        end
        return k;
    endfunction

    // Bits following the run and its terminator, left-aligned, zero-filled past the LSB.
    function automatic logic [N-4:0] tail_bits(input logic [N-2:0] rem, input logic [RS-1:0] k);
        logic [N-4:0] f;
        int           src;
        f = '0;
        for (int m = 0; m < N - 3; m++) begin
            src = N - 3 - int'(k) - m;
            if (src >= 0) begin
                f[N-4-m] = rem[src];
            end else begin
                f[N-4-m] = 1'b0;
            end
        end
        return f;
    endfunction

    logic            s1_valid_q, s1_sign_q, s1_zero_q, s1_nar_q;
    logic [N-2:0]    s1_rem_q;
    logic [TW-1:0]   s1_tag_q;
    logic            s1_sign_d, s1_zero_d, s1_nar_d;
    logic [N-2:0]    s1_rem_d;

    logic            out_valid_q, sign_q, zero_q, nar_q;
    logic signed [RS-1:0] regime_q, regime_d;
    logic [ES-1:0]   exp_q, exp_d;
    logic [FW:0]     mant_q, mant_d;
    logic [TW-1:0]   tag_q;
    logic [RS-1:0]   k_s;
    logic [N-4:0]    field_s;
    logic            s1_en_s, s2_en_s;

    assign s2_en_s = !out_valid_q || OutReady;
    assign s1_en_s = !s1_valid_q || s2_en_s;
    assign InReady = s1_en_s;

    // S1 next state: sign, special-value flags and body magnitude.
    always_comb begin
        s1_sign_d = In[N-1];
        s1_zero_d = (In == '0);
        s1_nar_d  = (In == {1'b1, {(N-1){1'b0}}});
        if (In[N-1]) begin
            s1_rem_d = ~In[N-2:0] + (N-1)'(1);
        end else begin
            s1_rem_d = In[N-2:0];
        end
    end

    // S2 next state: regime / exponent / fraction decode, zeroed for specials.
    always_comb begin
        k_s     = run_len(s1_rem_q);
        field_s = tail_bits(s1_rem_q, k_s);
        if (s1_zero_q || s1_nar_q) begin
            regime_d = '0;
            exp_d    = '0;
            mant_d   = '0;
        end else begin
            if (s1_rem_q[N-2]) begin
                regime_d = $signed(k_s - RS'(1));
            end else begin
                regime_d = -$signed(k_s);
            end
            exp_d  = field_s[N-4 -: ES];
            mant_d = {1'b1, field_s[FW-1:0]};
        end
    end

    // Stage 1 register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_nar_q   <= 1'b0;
            s1_rem_q   <= '0;
            s1_tag_q   <= '0;
        end else if (s1_en_s) begin
            s1_valid_q <= InValid;
            if (InValid) begin
                s1_sign_q <= s1_sign_d;
                s1_zero_q <= s1_zero_d;
                s1_nar_q  <= s1_nar_d;
                s1_rem_q  <= s1_rem_d;
                s1_tag_q  <= InTag;
            end
        end
    end

    // Stage 2 (output) register; holds while stalled.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            out_valid_q <= 1'b0;
            sign_q      <= 1'b0;
            zero_q      <= 1'b0;
            nar_q       <= 1'b0;
            regime_q    <= '0;
            exp_q       <= '0;
            mant_q      <= '0;
            tag_q       <= '0;
        end else if (s2_en_s) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                sign_q   <= s1_sign_q;
                zero_q   <= s1_zero_q;
                nar_q    <= s1_nar_q;
                regime_q <= regime_d;
                exp_q    <= exp_d;
                mant_q   <= mant_d;
                tag_q    <= s1_tag_q;
            end
        end
    end

    assign OutValid    = out_valid_q;
    assign Sign        = sign_q;
    assign Zero        = zero_q;
    assign NaR         = nar_q;
    assign RegimeValue = regime_q;
    assign Exponent    = exp_q;
    assign Mantissa    = mant_q;
    // Exponent is unsigned and ES wide, so the scale is a plain concatenation.
    assign TotalExp    = {regime_q, exp_q};
    assign OutTag      = tag_q;
endmodule
